// File: rtl/tag_flush_ctrl_pkg.sv
// ============================================================================
// Module  : tag_flush_ctrl_pkg
// Brief   : Shared cache-bank definitions: tag-sequencer state encoding and
//           line-select width derivation, reused by the tag/data access blocks.
// Revision: 1.0
// ============================================================================
`default_nettype none

package tag_flush_ctrl_pkg;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_FLUSH = 1'b1;

   function automatic int line_select_bits(input int lines);
      return $clog2(lines);
   endfunction

endpackage

`default_nettype wire

// File: rtl/tag_flush_ctrl.sv
// ============================================================================
// Module  : tag_flush_ctrl
// Brief   : Tag-store port sequencer: flush walker plus fill > flush > lookup
//           arbitration onto the single tag-store port of one cache bank.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tag_flush_ctrl
   import tag_flush_ctrl_pkg::*;
#(
   parameter int LINES_PER_BANK  = 64,
   parameter int LINE_ADDR_WIDTH = 26
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       stall,
   input  logic                       flush_valid,
   output logic                       flush_ready,
   input  logic                       fill_valid,
   input  logic [LINE_ADDR_WIDTH-1:0] fill_addr,
   output logic                       fill_ready,
   input  logic                       lookup_valid,
   input  logic [LINE_ADDR_WIDTH-1:0] lookup_addr,
   output logic                       lookup_ready,
   output logic                       tag_lookup,
   output logic                       tag_fill,
   output logic                       tag_is_flush,
   output logic [LINE_ADDR_WIDTH-1:0] tag_addr,
   output logic                       busy,
   output logic                       flush_done
);

   localparam int LINE_SELECT_BITS = line_select_bits(LINES_PER_BANK);
   localparam logic [LINE_SELECT_BITS-1:0] c_LAST_LINE = LINE_SELECT_BITS'(LINES_PER_BANK - 1);

   logic [0:0]                  state_q, state_d;
   logic [LINE_SELECT_BITS-1:0] cnt_q, cnt_d;
   logic                        flush_done_q, flush_done_d;
   logic [LINE_ADDR_WIDTH-1:0]  w_cnt_ext;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      flush_done_d = 1'b0;
      flush_ready  = 1'b0;
      fill_ready   = 1'b0;
      lookup_ready = 1'b0;
      tag_lookup   = 1'b0;
      tag_fill     = 1'b0;
      tag_is_flush = 1'b0;
      busy         = 1'b0;
      tag_addr     = lookup_addr;
      w_cnt_ext    = '0;
      w_cnt_ext[LINE_SELECT_BITS-1:0] = cnt_q;

      // Reset gates the port combinationally so nothing reaches the tag store.
      if (reset) begin
         busy     = 1'b1;
         tag_addr = '0;
      end else begin
         case (state_q)
            ST_FLUSH: begin
               busy     = 1'b1;
               tag_addr = w_cnt_ext;
               if (!stall) begin
                  tag_fill     = 1'b1;
                  tag_is_flush = 1'b1;
                  cnt_d        = cnt_q + LINE_SELECT_BITS'(1);
                  if (cnt_q == c_LAST_LINE) begin
                     state_d      = ST_IDLE;
                     flush_done_d = 1'b1;
                  end
               end
            end
            default: begin
               fill_ready   = !stall && fill_valid;
               flush_ready  = !stall && flush_valid && !fill_valid;
               lookup_ready = !stall && lookup_valid && !fill_valid && !flush_valid;
               tag_fill     = fill_ready;
               tag_lookup   = lookup_ready;
               if (fill_ready) begin
                  tag_addr = fill_addr;
               end
               if (flush_ready) begin
                  state_d = ST_FLUSH;
                  cnt_d   = '0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_FLUSH;
         cnt_q        <= '0;
         flush_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         flush_done_q <= flush_done_d;
      end
   end

   assign flush_done = flush_done_q;

endmodule

`default_nettype wire

// File: tb/tb_tag_flush_ctrl.sv
// ============================================================================
// Module  : tb_tag_flush_ctrl
// Brief   : Directed bench for tag_flush_ctrl with a per-cycle reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tag_flush_ctrl;

   localparam int LINES = 8;
   localparam int AW    = 26;

   logic          clk          = 1'b0;
   logic          reset        = 1'b1;
   logic          stall        = 1'b0;
   logic          flush_valid  = 1'b0;
   logic          fill_valid   = 1'b0;
   logic          lookup_valid = 1'b0;
   logic [AW-1:0] fill_addr    = '0;
   logic [AW-1:0] lookup_addr  = '0;

   logic          flush_ready, fill_ready, lookup_ready;
   logic          tag_lookup, tag_fill, tag_is_flush, busy, flush_done;
   logic [AW-1:0] tag_addr;

   int vectors     = 0;
   int miscompares = 0;

   tag_flush_ctrl #(
      .LINES_PER_BANK (LINES),
      .LINE_ADDR_WIDTH(AW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .flush_valid (flush_valid),
      .flush_ready (flush_ready),
      .fill_valid  (fill_valid),
      .fill_addr   (fill_addr),
      .fill_ready  (fill_ready),
      .lookup_valid(lookup_valid),
      .lookup_addr (lookup_addr),
      .lookup_ready(lookup_ready),
      .tag_lookup  (tag_lookup),
      .tag_fill    (tag_fill),
      .tag_is_flush(tag_is_flush),
      .tag_addr    (tag_addr),
      .busy        (busy),
      .flush_done  (flush_done)
   );

   always #5 clk = ~clk;

   task automatic chk1(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chka(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: walking flag, next line to invalidate, pending done pulse.
   bit m_walk = 1'b1;
   int m_pos  = 0;
   bit m_done = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_walk <= 1'b1;
         m_pos  <= 0;
         m_done <= 1'b0;
      end else if (m_walk) begin
         m_done <= 1'b0;
         if (!stall) begin
            if (m_pos == LINES - 1) begin
               m_walk <= 1'b0;
               m_pos  <= 0;
               m_done <= 1'b1;
            end else begin
               m_pos <= m_pos + 1;
            end
         end
      end else begin
         m_done <= 1'b0;
         if (!stall && flush_valid && !fill_valid) begin
            m_walk <= 1'b1;
            m_pos  <= 0;
         end
      end
   end

   logic          e_flr, e_fr, e_lr, e_lk, e_fl, e_isf, e_busy, e_done, e_chk_addr;
   logic [AW-1:0] e_addr;

   always @(negedge clk) begin
      e_flr = 1'b0; e_fr = 1'b0; e_lr = 1'b0; e_lk = 1'b0; e_fl = 1'b0; e_isf = 1'b0;
      e_busy = 1'b0; e_done = m_done; e_chk_addr = 1'b1; e_addr = lookup_addr;
      if (reset) begin
         e_busy = 1'b1;
         e_done = 1'b0;
         e_addr = '0;
      end else if (m_walk) begin
         e_busy = 1'b1;
         if (!stall) begin
            e_fl   = 1'b1;
            e_isf  = 1'b1;
            e_addr = AW'(m_pos);
         end else begin
            e_chk_addr = 1'b0;
         end
      end else begin
         e_fr  = !stall && fill_valid;
         e_flr = !stall && flush_valid && !fill_valid;
         e_lr  = !stall && lookup_valid && !fill_valid && !flush_valid;
         e_fl  = e_fr;
         e_lk  = e_lr;
         if (e_fr) e_addr = fill_addr;
      end
      chk1("m_flush_ready",  flush_ready,  e_flr);
      chk1("m_fill_ready",   fill_ready,   e_fr);
      chk1("m_lookup_ready", lookup_ready, e_lr);
      chk1("m_tag_lookup",   tag_lookup,   e_lk);
      chk1("m_tag_fill",     tag_fill,     e_fl);
      chk1("m_tag_is_flush", tag_is_flush, e_isf);
      chk1("m_busy",         busy,         e_busy);
      chk1("m_flush_done",   flush_done,   e_done);
      if (e_chk_addr) chka("m_tag_addr", tag_addr, e_addr);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Expects a fresh walk starting in the current cycle; leaves the DUT idle.
   task automatic walk_check();
      for (int i = 0; i < LINES; i++) begin
         @(negedge clk);
         chk1("walk_fill", tag_fill, 1'b1);
         chka("walk_addr", tag_addr, AW'(i));
         cyc();
      end
      @(negedge clk);
      chk1("done_pulse", flush_done, 1'b1);
      chk1("busy_low", busy, 1'b0);
      cyc();
      @(negedge clk);
      chk1("done_clear", flush_done, 1'b0);
      cyc();
   endtask

   initial begin
      // Reset state and power-on walk
      @(negedge clk);
      chk1("rst_fill", tag_fill, 1'b0);
      chk1("rst_busy", busy, 1'b1);
      chka("rst_addr", tag_addr, '0);
      cyc(); cyc();
      reset = 1'b0;
      walk_check();

      // Requested walk with a 2-cycle stall at line 2
      flush_valid = 1'b1;
      @(negedge clk);
      chk1("req_flush_ready", flush_ready, 1'b1);
      chk1("req_no_op", tag_fill, 1'b0);
      cyc();
      flush_valid = 1'b0;
      @(negedge clk);
      chk1("req_busy", busy, 1'b1);
      cyc(); cyc();
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk1("stall_no_fill", tag_fill, 1'b0);
         cyc();
      end
      stall = 1'b0;
      @(negedge clk);
      chk1("resume_fill", tag_fill, 1'b1);
      chka("resume_addr", tag_addr, AW'(2));
      repeat (6) cyc();
      @(negedge clk);
      chk1("stall_done", flush_done, 1'b1);
      cyc();

      // Priority: fill, then flush, then lookup after the walk
      fill_valid = 1'b1; fill_addr = AW'(32'h40);
      flush_valid = 1'b1;
      lookup_valid = 1'b1; lookup_addr = AW'(32'h80);
      @(negedge clk);
      chk1("pri_fill_ready", fill_ready, 1'b1);
      chka("pri_fill_addr", tag_addr, AW'(32'h40));
      chk1("pri_lookup_blocked", lookup_ready, 1'b0);
      cyc();
      fill_valid = 1'b0;
      @(negedge clk);
      chk1("pri_flush_ready", flush_ready, 1'b1);
      chk1("pri_no_lookup", tag_lookup, 1'b0);
      cyc();
      flush_valid = 1'b0;
      for (int i = 0; i < LINES; i++) begin
         @(negedge clk);
         chk1("walk_lookup_blocked", lookup_ready, 1'b0);
         cyc();
      end
      @(negedge clk);
      chk1("pri_done", flush_done, 1'b1);
      chk1("pri_lookup", tag_lookup, 1'b1);
      chka("pri_lookup_addr", tag_addr, AW'(32'h80));
      cyc();

      // Back-to-back lookups
      lookup_addr = AW'(32'h11);
      @(negedge clk); chk1("b2b_lk0", tag_lookup, 1'b1); chka("b2b_a0", tag_addr, AW'(32'h11));
      cyc(); lookup_addr = AW'(32'h22);
      @(negedge clk); chk1("b2b_lk1", tag_lookup, 1'b1); chka("b2b_a1", tag_addr, AW'(32'h22));
      cyc(); lookup_addr = AW'(32'h33);
      @(negedge clk); chk1("b2b_lk2", tag_lookup, 1'b1); chka("b2b_a2", tag_addr, AW'(32'h33));
      cyc();
      lookup_valid = 1'b0;

      // Fill held off by stall
      stall = 1'b1; fill_valid = 1'b1; fill_addr = AW'(32'h1234);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk1("stall_fill_ready", fill_ready, 1'b0);
         chk1("stall_tag_fill", tag_fill, 1'b0);
         cyc();
      end
      stall = 1'b0;
      @(negedge clk);
      chk1("unstall_fill_ready", fill_ready, 1'b1);
      chka("unstall_fill_addr", tag_addr, AW'(32'h1234));
      cyc();
      fill_valid = 1'b0;

      // Reset mid-walk at line 5
      flush_valid = 1'b1;
      cyc();
      flush_valid = 1'b0;
      repeat (5) cyc();
      @(negedge clk);
      chka("mid_addr5", tag_addr, AW'(5));
      #2 reset = 1'b1;
      #1;
      chk1("mid_rst_fill", tag_fill, 1'b0);
      chk1("mid_rst_busy", busy, 1'b1);
      chka("mid_rst_addr", tag_addr, '0);
      cyc(); cyc();
      reset = 1'b0;
      walk_check();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
